calc_bus_arbiter: RTL and testbench

//  Two-requester arbiter/sequencer for the calculator's shared 16-bit operand bus.

---
 rtl/calc_bus_arbiter.sv | 128 ++++++++++++
 tb/tb_calc_bus_arbiter.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/calc_bus_arbiter.sv
// rtl/calc_bus_arbiter.sv - two-source round-robin bus arbiter with hold limit and registered operand mux
// Define ARB_FIXED_PRIO_EN to make idle ties always favour source 0.
module calc_bus_arbiter #(
  parameter int WIDTH    = 16,
  parameter int HOLD_MAX = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0,
  input  logic             req1,
  input  logic             done0,
  input  logic             done1,
  input  logic [WIDTH-1:0] data0,
  input  logic [WIDTH-1:0] data1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             sel,
  output logic [WIDTH-1:0] bus_data,
  output logic             bus_valid,
  output logic             preempt
);

  localparam int            CW       = $clog2(HOLD_MAX + 1);
  localparam logic [CW-1:0] HOLD_LIM = CW'(HOLD_MAX);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    G0   = 2'd1,
    G1   = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] hold_cnt;
  logic          tie_src;
  logic          cur_req;
  logic          cur_done;
  logic          oth_req;
  logic          hold_hit;
  logic          release_now;
  logic          hold_only;
  logic          enter;
  logic          enter_src;

`ifdef ARB_FIXED_PRIO_EN
  assign tie_src = 1'b0;
`else
  logic rr_last;
  assign tie_src = ~rr_last;
`endif

  assign gnt0 = (state == G0);
  assign gnt1 = (state == G1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    cur_req     = (state == G1) ? req1 : req0;
    cur_done    = (state == G1) ? done1 : done0;
    oth_req     = (state == G1) ? req0 : req1;
    hold_hit    = (hold_cnt == HOLD_LIM);
    release_now = 1'b0;
    hold_only   = 1'b0;
    enter       = 1'b0;
    enter_src   = 1'b0;
    state_nxt   = state;
    case (state)
      IDLE: begin
        if (req0 | req1) begin
          enter     = 1'b1;
          enter_src = (req0 & req1) ? tie_src : req1;
          state_nxt = enter_src ? G1 : G0;
        end
      end
      G0, G1: begin
        release_now = cur_done | ~cur_req | (hold_hit & oth_req);
        // Preempt only when nothing but the hold limit ended the grant.
        hold_only   = ~cur_done & cur_req & hold_hit & oth_req;
        if (release_now) begin
          if (oth_req) begin
            enter     = 1'b1;
            enter_src = (state == G0);
            state_nxt = enter_src ? G1 : G0;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel       <= 1'b0;
      hold_cnt  <= '0;
      bus_data  <= '0;
      bus_valid <= 1'b0;
      preempt   <= 1'b0;
`ifndef ARB_FIXED_PRIO_EN
      rr_last   <= 1'b1;
`endif
    end else begin
      preempt <= hold_only;
      if (enter) begin
        sel      <= enter_src;
        hold_cnt <= CW'(1);
`ifndef ARB_FIXED_PRIO_EN
        rr_last  <= enter_src;
`endif
      end else if (state != IDLE && !hold_hit) begin
        hold_cnt <= hold_cnt + CW'(1);
      end
      // sel still names the owner here; the word is captured even on the releasing edge.
      if (state != IDLE) begin
        bus_data  <= sel ? data1 : data0;
        bus_valid <= ~release_now;
      end
    end
  end

endmodule

// File: tb/tb_calc_bus_arbiter.sv
// tb/tb_calc_bus_arbiter.sv - directed and random checks of calc_bus_arbiter against an ownership model
module tb_calc_bus_arbiter;

  localparam int HM = 8;

  logic        clk;
  logic        rst_n;
  logic        req0, req1, done0, done1;
  logic [15:0] data0, data1;
  logic        gnt0, gnt1, sel, bus_valid, preempt;
  logic [15:0] bus_data;

  int errors = 0;
  int checks = 0;

  // Reference: who owns the bus, who last won, how long the owner has held it.
  int          m_owner;
  int          m_last;
  int          m_ten;
  logic        m_sel;
  logic [15:0] m_data;
  logic        m_valid;
  logic        m_pre;

  calc_bus_arbiter #(.WIDTH(16), .HOLD_MAX(HM)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1), .done0(done0), .done1(done1),
    .data0(data0), .data1(data1),
    .gnt0(gnt0), .gnt1(gnt1), .sel(sel),
    .bus_data(bus_data), .bus_valid(bus_valid), .preempt(preempt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = -1; m_last = 1; m_ten = 0; m_sel = 1'b0;
    m_data = 16'h0000; m_valid = 1'b0; m_pre = 1'b0;
  endtask

  task automatic grant(input int s);
    m_owner = s; m_last = s; m_sel = (s == 1); m_ten = 1;
  endtask

  task automatic model_step();
    logic mr, md, orq;
    m_pre = 1'b0;
    if (m_owner < 0) begin
      if (req0 && req1) begin
`ifdef ARB_FIXED_PRIO_EN
        grant(0);
`else
        grant(1 - m_last);
`endif
      end else if (req0) grant(0);
      else if (req1) grant(1);
    end else begin
      mr  = (m_owner == 0) ? req0 : req1;
      md  = (m_owner == 0) ? done0 : done1;
      orq = (m_owner == 0) ? req1 : req0;
      m_data = (m_owner == 0) ? data0 : data1;
      if (md || !mr || (m_ten >= HM && orq)) begin
        m_pre   = mr && !md;
        m_valid = 1'b0;
        if (orq) grant(1 - m_owner);
        else m_owner = -1;
      end else begin
        m_valid = 1'b1;
        if (m_ten < HM) m_ten++;
      end
    end
  endtask

  task automatic compare_all(input string tag);
    chk({tag, ".gnt0"}, 32'(gnt0), 32'(m_owner == 0));
    chk({tag, ".gnt1"}, 32'(gnt1), 32'(m_owner == 1));
    chk({tag, ".sel"}, 32'(sel), 32'(m_sel));
    chk({tag, ".bus_data"}, 32'(bus_data), 32'(m_data));
    chk({tag, ".bus_valid"}, 32'(bus_valid), 32'(m_valid));
    chk({tag, ".preempt"}, 32'(preempt), 32'(m_pre));
  endtask

  task automatic cycle(input string tag);
    model_step();
    @(posedge clk);
    #1;
    compare_all(tag);
  endtask

  task automatic drive(input logic r0, input logic r1, input logic d0, input logic d1);
    req0 = r0; req1 = r1; done0 = d0; done1 = d1;
  endtask

  task automatic mid_reset(input string tag);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk({tag, ".gnt0"}, 32'(gnt0), 32'd0);
    chk({tag, ".gnt1"}, 32'(gnt1), 32'd0);
    chk({tag, ".sel"}, 32'(sel), 32'd0);
    chk({tag, ".bus_data"}, 32'(bus_data), 32'h0000);
    chk({tag, ".bus_valid"}, 32'(bus_valid), 32'd0);
    chk({tag, ".preempt"}, 32'(preempt), 32'd0);
    drive(0, 0, 0, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b1;
    drive(0, 0, 0, 0);
    data0 = 16'h0000;
    data1 = 16'h0000;
    model_reset();

    // Reset mid-cycle
    mid_reset("reset");

    // Single request on source 0
    data0 = 16'h1234;
    drive(1, 0, 0, 0);
    cycle("single.grant");
    chk("single.gnt0_now", 32'(gnt0), 32'd1);
    cycle("single.data");
    chk("single.word", 32'(bus_data), 32'h1234);
    chk("single.valid", 32'(bus_valid), 32'd1);
    drive(0, 0, 1, 0);
    cycle("single.done");
    chk("single.idle_gnt0", 32'(gnt0), 32'd0);
    chk("single.idle_valid", 32'(bus_valid), 32'd0);
    drive(0, 0, 0, 0);
    cycle("single.idle");

    // Tie from reset goes to source 0, then zero-bubble handoff
    mid_reset("reset2");
    data0 = 16'hCAFE;
    data1 = 16'hBEEF;
    drive(1, 1, 0, 0);
    cycle("tie.first");
    chk("tie.first_g0", 32'(gnt0), 32'd1);
    drive(0, 1, 1, 0);
    cycle("tie.handoff");
    chk("tie.handoff_g1", 32'(gnt1), 32'd1);
    chk("tie.handoff_sel", 32'(sel), 32'd1);
    drive(0, 1, 0, 0);
    cycle("tie.g1data");
    chk("tie.beef", 32'(bus_data), 32'hBEEF);
    drive(0, 0, 0, 1);
    cycle("tie.g1done");
    drive(1, 1, 0, 0);
    cycle("tie.second");
    chk("tie.second_g0", 32'(gnt0), 32'd1);
    drive(0, 0, 1, 0);
    cycle("tie.release");
    drive(1, 1, 0, 0);
    cycle("tie.third");
`ifdef ARB_FIXED_PRIO_EN
    chk("tie.third_owner", 32'(gnt0), 32'd1);
`else
    chk("tie.third_owner", 32'(gnt1), 32'd1);
`endif
    drive(0, 0, 0, 0);
    cycle("tie.drain");
    cycle("tie.idle");

    // Hold limit with competitor waiting: preempt after HM grant cycles
    drive(1, 0, 0, 0);
    cycle("hold.enter");
    drive(1, 1, 0, 1);
    for (int i = 0; i < HM - 1; i++) begin
      cycle("hold.run");
      drive(1, 1, 0, 0);
      chk("hold.still_g0", 32'(gnt0), 32'd1);
    end
    cycle("hold.rotate");
    chk("hold.rot_g1", 32'(gnt1), 32'd1);
    chk("hold.preempt", 32'(preempt), 32'd1);
    drive(1, 1, 0, 1);
    cycle("hold.after");
    chk("hold.preempt_clr", 32'(preempt), 32'd0);
    drive(0, 0, 0, 0);
    cycle("hold.drain");
    cycle("hold.idle");

    // Hold limit with no competitor: grant persists, no preempt
    drive(1, 0, 0, 0);
    for (int i = 0; i < HM + 4; i++) cycle("nohold.run");
    chk("nohold.g0", 32'(gnt0), 32'd1);
    chk("nohold.preempt", 32'(preempt), 32'd0);

    // Limit and done0 together: switch without preempt
    drive(1, 1, 1, 0);
    cycle("corner.done_limit");
    chk("corner.g1", 32'(gnt1), 32'd1);
    chk("corner.nopre", 32'(preempt), 32'd0);
    drive(0, 0, 0, 0);
    cycle("corner.drain");

    // Reset while a grant is active
    drive(1, 0, 0, 0);
    cycle("midgrant.enter");
    cycle("midgrant.hold");
    mid_reset("midgrant.reset");

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      req0  = ($urandom_range(0, 3) != 0);
      req1  = ($urandom_range(0, 3) != 0);
      done0 = ($urandom_range(0, 9) == 0);
      done1 = ($urandom_range(0, 9) == 0);
      data0 = 16'($urandom);
      data1 = 16'($urandom);
      cycle("rand");
      if (i == 300) mid_reset("rand.reset");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
